// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the IF-stage branch predictor: counter encodings and PC geometry.
package branch_predictor_pkg;

    localparam int unsigned PcW = 16;

    typedef enum logic [1:0] {
        CntSnt = 2'b00,
        CntWnt = 2'b01,
        CntWt  = 2'b10,
        CntSt  = 2'b11
    } cnt_e;

    localparam cnt_e CntAlloc = CntWt;
    localparam cnt_e CntReset = CntWnt;

    function automatic int unsigned tag_w(int unsigned idx_w);
        return PcW - idx_w;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Signal bundle between the pipeline (master) and the branch predictor (slave).
interface branch_predictor_if
    import branch_predictor_pkg::*;
#(
    parameter int unsigned CNT_W = 16
);
    logic [PcW-1:0]   pc_if_i;
    logic             prediction_o;
    logic [PcW-1:0]   pred_target_o;
    logic             stall_if_i;
    logic             flush_if_i;
    logic             flush_id_i;
    logic             prediction_id_o;
    logic [PcW-1:0]   pc_id_i;
    logic [PcW-1:0]   target_id_i;
    logic             ifbranch_i;
    logic             precorrc_i;
    logic             prewrong_i;
    logic [CNT_W-1:0] branch_cnt_o;
    logic [CNT_W-1:0] miss_cnt_o;

    modport slave (
        input  pc_if_i, stall_if_i, flush_if_i, flush_id_i, pc_id_i, target_id_i,
        input  ifbranch_i, precorrc_i, prewrong_i,
        output prediction_o, pred_target_o, prediction_id_o, branch_cnt_o, miss_cnt_o
    );

    modport master (
        output pc_if_i, stall_if_i, flush_if_i, flush_id_i, pc_id_i, target_id_i,
        output ifbranch_i, precorrc_i, prewrong_i,
        input  prediction_o, pred_target_o, prediction_id_o, branch_cnt_o, miss_cnt_o
    );

endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating up/down counter with enable and an allocation load.
module branch_predictor_sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic       i_load,
    input  logic       i_up,
    output logic [1:0] o_cnt
);

    logic [1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= CntReset;
        end else if (i_en) begin
            if (i_load) begin
                r_cnt <= CntAlloc;
            end else if (i_up && r_cnt != CntSt) begin
                r_cnt <= r_cnt + 2'd1;
            end else if (!i_up && r_cnt != CntSnt) begin
                r_cnt <= r_cnt - 2'd1;
            end
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit BHT with tagged targets, trained from ID verdicts; lookup is combinational.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned IDX_W = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic              CLK,
    input  logic              RST,
    branch_predictor_if.slave bus
);

    localparam int unsigned Depth = 1 << IDX_W;
    localparam int unsigned TagW  = tag_w(IDX_W);

    logic             r_valid [Depth];
    logic [TagW-1:0]  r_tag   [Depth];
    logic [PcW-1:0]   r_tgt   [Depth];
    logic [1:0]       w_cnt   [Depth];
    logic             r_pred_id;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_miss_cnt;

    logic [IDX_W-1:0] w_idx;
    logic [TagW-1:0]  w_tag;
    logic             w_hit;
    logic [IDX_W-1:0] w_j;
    logic [TagW-1:0]  w_tg;
    logic             w_match;
    logic             w_upd;

    assign w_idx = bus.pc_if_i[IDX_W-1:0];
    assign w_tag = bus.pc_if_i[PcW-1:IDX_W];
    assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    assign bus.prediction_o    = w_hit && w_cnt[w_idx][1];
    assign bus.pred_target_o   = r_tgt[w_idx];
    assign bus.prediction_id_o = r_pred_id;
    assign bus.branch_cnt_o    = r_branch_cnt;
    assign bus.miss_cnt_o      = r_miss_cnt;

    // Both verdicts at once is illegal; it still trains once and counts as a miss.
    assign w_upd   = bus.precorrc_i | bus.prewrong_i;
    assign w_j     = bus.pc_id_i[IDX_W-1:0];
    assign w_tg    = bus.pc_id_i[PcW-1:IDX_W];
    assign w_match = r_valid[w_j] && (r_tag[w_j] == w_tg);

    for (genvar k = 0; k < Depth; k++) begin : g_cnt
        logic w_en;
        assign w_en = w_upd && (w_j == IDX_W'(k)) && (w_match || bus.ifbranch_i);

        branch_predictor_sat_counter2 u_cnt (
            .i_clk  (CLK),
            .i_rst  (RST),
            .i_en   (w_en),
            .i_load (!w_match),
            .i_up   (bus.ifbranch_i),
            .o_cnt  (w_cnt[k])
        );
    end

    // A taken outcome always writes tag/target; on a hit the tag is unchanged anyway.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < Depth; k++) begin
                r_valid[k] <= 1'b0;
                r_tag[k]   <= '0;
                r_tgt[k]   <= '0;
            end
        end else if (w_upd && bus.ifbranch_i) begin
            r_valid[w_j] <= 1'b1;
            r_tag[w_j]   <= w_tg;
            r_tgt[w_j]   <= bus.target_id_i;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || bus.flush_id_i || bus.flush_if_i) begin
            r_pred_id <= 1'b0;
        end else if (!bus.stall_if_i) begin
            r_pred_id <= bus.prediction_o;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_branch_cnt <= '0;
            r_miss_cnt   <= '0;
        end else if (w_upd) begin
            if (r_branch_cnt != '1) begin
                r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            end
            if (bus.prewrong_i && r_miss_cnt != '1) begin
                r_miss_cnt <= r_miss_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed and randomized bench for branch_predictor against a table-level reference model.
module tb_branch_predictor;

    localparam int CntW   = 6;
    localparam int CntMax = (1 << CntW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    branch_predictor_if #(.CNT_W(CntW)) bus ();

    branch_predictor #(.IDX_W(4), .CNT_W(CntW)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    bit m_valid [16];
    int m_tag   [16];
    int m_tgt   [16];
    int m_cnt   [16];
    int m_bc;
    int m_mc;
    bit m_pid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_pred(input int pc);
        int i;
        i = pc % 16;
        return m_valid[i] && (m_tag[i] == pc / 16) && (m_cnt[i] >= 2);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_tgt[i]   = 0;
            m_cnt[i]   = 1;
        end
        m_bc  = 0;
        m_mc  = 0;
        m_pid = 1'b0;
    endtask

    task automatic m_train(input int pc, input int tgt, input bit taken, input bit wrong);
        int j;
        j = pc % 16;
        if (m_valid[j] && m_tag[j] == pc / 16) begin
            m_cnt[j] = taken ? ((m_cnt[j] == 3) ? 3 : m_cnt[j] + 1)
                             : ((m_cnt[j] == 0) ? 0 : m_cnt[j] - 1);
            if (taken) m_tgt[j] = tgt;
        end else if (taken) begin
            m_valid[j] = 1'b1;
            m_tag[j]   = pc / 16;
            m_tgt[j]   = tgt;
            m_cnt[j]   = 2;
        end
        if (m_bc < CntMax) m_bc++;
        if (wrong && m_mc < CntMax) m_mc++;
    endtask

    // Advance one edge; the model sees the inputs driven for this cycle.
    task automatic tick();
        bit pre_pred;
        pre_pred = m_pred(int'(bus.pc_if_i));
        @(posedge clk);
        if (rst) begin
            m_reset();
        end else begin
            if (bus.flush_id_i || bus.flush_if_i) m_pid = 1'b0;
            else if (!bus.stall_if_i) m_pid = pre_pred;
            if (bus.precorrc_i || bus.prewrong_i)
                m_train(int'(bus.pc_id_i), int'(bus.target_id_i), bus.ifbranch_i, bus.prewrong_i);
        end
        #1;
    endtask

    task automatic check_all(input string tag);
        #1;
        check({tag, ".pred"}, 32'(bus.prediction_o), 32'(m_pred(int'(bus.pc_if_i))));
        if (m_pred(int'(bus.pc_if_i)))
            check({tag, ".tgt"}, 32'(bus.pred_target_o), 32'(m_tgt[bus.pc_if_i % 16]));
        check({tag, ".pid"}, 32'(bus.prediction_id_o), 32'(m_pid));
        check({tag, ".bc"}, 32'(bus.branch_cnt_o), 32'(m_bc));
        check({tag, ".mc"}, 32'(bus.miss_cnt_o), 32'(m_mc));
    endtask

    task automatic set_upd(input int pc, input int tgt, input bit taken, input bit c, input bit w);
        bus.pc_id_i     = 16'(pc);
        bus.target_id_i = 16'(tgt);
        bus.ifbranch_i  = taken;
        bus.precorrc_i  = c;
        bus.prewrong_i  = w;
    endtask

    initial begin
        bus.pc_if_i    = '0;
        bus.stall_if_i = 1'b0;
        bus.flush_if_i = 1'b0;
        bus.flush_id_i = 1'b0;
        set_upd(0, 0, 1'b0, 1'b0, 1'b0);
        m_reset();

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        bus.pc_if_i = 16'h0013;
        #1;
        check("rst.pred", 32'(bus.prediction_o), 32'd0);
        check("rst.pid", 32'(bus.prediction_id_o), 32'd0);
        check("rst.bc", 32'(bus.branch_cnt_o), 32'd0);
        check("rst.mc", 32'(bus.miss_cnt_o), 32'd0);

        // First taken branch allocates with weak-taken.
        set_upd(16'h0013, 16'h0040, 1'b1, 1'b0, 1'b1);
        tick();
        set_upd(0, 0, 1'b0, 1'b0, 1'b0);
        bus.pc_if_i = 16'h0013;
        #1;
        check("alloc.pred", 32'(bus.prediction_o), 32'd1);
        check("alloc.tgt", 32'(bus.pred_target_o), 32'h0040);
        check("alloc.bc", 32'(bus.branch_cnt_o), 32'd1);
        check("alloc.mc", 32'(bus.miss_cnt_o), 32'd1);

        bus.pc_if_i = 16'h0023;
        #1;
        check("alias.pred", 32'(bus.prediction_o), 32'd0);

        // Copy register: settle to 0, then stall with a taken prediction in IF.
        tick();
        bus.pc_if_i = 16'h0013;
        bus.stall_if_i = 1'b1;
        tick();
        tick();
        check("stall.pid", 32'(bus.prediction_id_o), 32'd0);
        bus.stall_if_i = 1'b0;
        tick();
        check("release.pid", 32'(bus.prediction_id_o), 32'd1);
        bus.stall_if_i = 1'b1;
        bus.flush_if_i = 1'b1;
        tick();
        check("flush.pid", 32'(bus.prediction_id_o), 32'd0);
        bus.stall_if_i = 1'b0;
        bus.flush_if_i = 1'b0;

        // Same-index update: lookup sees the old counter, no bypass.
        set_upd(16'h0013, 16'h0040, 1'b0, 1'b1, 1'b0);
        #1;
        check("same.old", 32'(bus.prediction_o), 32'd1);
        tick();
        set_upd(0, 0, 1'b0, 1'b0, 1'b0);
        #1;
        check("same.new", 32'(bus.prediction_o), 32'd0);

        set_upd(16'h0013, 16'h0040, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        set_upd(16'h0013, 16'h0050, 1'b1, 1'b0, 1'b1);
        tick();
        set_upd(0, 0, 1'b0, 1'b0, 1'b0);
        check_all("ntsat");
        check("ntsat.pred", 32'(bus.prediction_o), 32'd0);

        // Reset coinciding with an update discards it.
        set_upd(16'h0005, 16'h1234, 1'b1, 1'b1, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_upd(0, 0, 1'b0, 1'b0, 1'b0);
        bus.pc_if_i = 16'h0005;
        #1;
        check("rstupd.pred", 32'(bus.prediction_o), 32'd0);
        check("rstupd.bc", 32'(bus.branch_cnt_o), 32'd0);

        for (int n = 0; n < 400; n++) begin
            bus.pc_if_i    = 16'(($urandom_range(0, 2) << 4) | $urandom_range(0, 3));
            bus.stall_if_i = ($urandom_range(0, 3) == 0);
            bus.flush_if_i = ($urandom_range(0, 9) == 0);
            bus.flush_id_i = ($urandom_range(0, 9) == 0);
            set_upd(($urandom_range(0, 2) << 4) | $urandom_range(0, 3), $urandom_range(0, 65535),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 2) == 0));
            rst = ($urandom_range(0, 99) == 0);
            check_all("rnd");
            tick();
        end
        rst = 1'b0;
        bus.stall_if_i = 1'b0;
        bus.flush_if_i = 1'b0;
        bus.flush_id_i = 1'b0;

        // Drive the statistics counters into saturation.
        for (int n = 0; n < CntMax + 4; n++) begin
            set_upd(16'h0031, 16'h0777, 1'b1, 1'b0, 1'b1);
            tick();
        end
        set_upd(0, 0, 1'b0, 1'b0, 1'b0);
        check_all("sat");
        check("sat.bc", 32'(bus.branch_cnt_o), 32'(CntMax));
        check("sat.mc", 32'(bus.miss_cnt_o), 32'(CntMax));
        set_upd(16'h0031, 16'h0777, 1'b0, 1'b1, 1'b0);
        tick();
        set_upd(0, 0, 1'b0, 1'b0, 1'b0);
        check("sat2.bc", 32'(bus.branch_cnt_o), 32'(CntMax));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
